// File: rtl/shift_ctrl.sv
// shift_ctrl: round-robin front end for a shared combinational SHIFT32.
// Logical shifts use one shifter pass; rotates OR two complementary passes.
module shift_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter bit FIRST_GNT  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic [1:0]            OP0,
    input  logic [DATA_WIDTH-1:0] D0,
    input  logic [DATA_WIDTH-1:0] AMT0,
    input  logic                  REQ1,
    input  logic [1:0]            OP1,
    input  logic [DATA_WIDTH-1:0] D1,
    input  logic [DATA_WIDTH-1:0] AMT1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  DONE0,
    output logic                  DONE1,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  BUSY,
    output logic [DATA_WIDTH-1:0] SH_D,
    output logic [DATA_WIDTH-1:0] SH_AMT,
    output logic                  SH_LNR,
    input  logic [DATA_WIDTH-1:0] SH_Y
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_d;
    logic [DATA_WIDTH-1:0]   r_amt;
    logic                    r_owner;
    logic                    r_last;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   r_result;

    logic                    w_idle;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_is_rot;
    logic [4:0]              w_rot_amt;
    logic [5:0]              w_rot_comp;

    assign w_idle     = (r_state == S_IDLE);
    assign w_is_rot   = r_op[1];
    assign w_rot_amt  = r_amt[4:0];
    assign w_rot_comp = 6'd32 - {1'b0, w_rot_amt};

    // r_last names the requester served most recently; the other wins ties
    assign w_gnt0 = w_idle && RST && REQ0 && (!REQ1 || r_last);
    assign w_gnt1 = w_idle && RST && REQ1 && (!REQ0 || !r_last);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt0 || w_gnt1) begin
                    w_next = S_PASS1;
                end
            end
            S_PASS1: begin
                if (w_is_rot && (w_rot_amt != 5'd0)) begin
                    w_next = S_PASS2;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_PASS2: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_op     <= 2'b00;
            r_d      <= '0;
            r_amt    <= '0;
            r_owner  <= 1'b0;
            r_last   <= ~FIRST_GNT;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_op    <= w_gnt1 ? OP1  : OP0;
                r_d     <= w_gnt1 ? D1   : D0;
                r_amt   <= w_gnt1 ? AMT1 : AMT0;
                r_owner <= w_gnt1;
                r_last  <= w_gnt1;
            end
            case (r_state)
                S_PASS1: r_acc    <= SH_Y;
                S_PASS2: r_acc    <= r_acc | SH_Y;
                S_DONE:  r_result <= r_acc;
                default: ;
            endcase
        end
    end

    always_comb begin
        SH_D   = '0;
        SH_AMT = '0;
        SH_LNR = 1'b0;
        unique case (r_state)
            S_PASS1: begin
                SH_D   = r_d;
                SH_LNR = r_op[0];
                if (w_is_rot) begin
                    SH_AMT = {{(DATA_WIDTH-5){1'b0}}, w_rot_amt};
                end else begin
                    SH_AMT = r_amt;
                end
            end
            S_PASS2: begin
                SH_D   = r_d;
                SH_LNR = ~r_op[0];
                SH_AMT = {{(DATA_WIDTH-6){1'b0}}, w_rot_comp};
            end
            default: ;
        endcase
    end

    // accumulator bypass makes RESULT valid in the same cycle as DONEx
    assign RESULT = (r_state == S_DONE) ? r_acc : r_result;
    assign DONE0  = (r_state == S_DONE) && !r_owner;
    assign DONE1  = (r_state == S_DONE) && r_owner;
    assign GNT0   = w_gnt0;
    assign GNT1   = w_gnt1;
    assign BUSY   = !w_idle;

endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
Two-requester controller that shares one SHIFT32 instance (combinational, 32-bit data, 32-bit amount, LnR: 1=left, 0=right, zero output when amount >= 32). Arbitrates round-robin, captures operands and sequences the shifter. Plain logical shifts take one shifter pass; rotates take two passes whose partial results are ORed. Sits between the ALU/issue logic and the shared shifter.

Parameters:
DATA_WIDTH, 32, operand/result width; only 32 is supported (matches SHIFT32).
FIRST_GNT, 0, requester that wins the first contended arbitration after reset.

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-low reset
REQ0  input  1  requester 0 request
OP0  input  2  requester 0 op: 00 SRL, 01 SLL, 10 ROR, 11 ROL
D0  input  32  requester 0 operand
AMT0  input  32  requester 0 shift amount
REQ1/OP1/D1/AMT1  input  1/2/32/32  same for requester 1
GNT0  output  1  one-cycle pulse: requester 0 operands captured
GNT1  output  1  one-cycle pulse: requester 1 operands captured
DONE0  output  1  one-cycle pulse: RESULT valid for requester 0
DONE1  output  1  one-cycle pulse: RESULT valid for requester 1
RESULT  output  32  registered result, held until next DONE
BUSY  output  1  high in any state other than IDLE
SH_D  output  32  to shifter D
SH_AMT  output  32  to shifter shift
SH_LNR  output  1  to shifter LnR
SH_Y  input  32  from shifter Y

Behaviour:
- Reset (RST=0 at a rising edge): state=IDLE; GNT*, DONE*, BUSY=0; RESULT=0; SH_D=0, SH_AMT=0, SH_LNR=0; accumulator=0; last-served pointer set so FIRST_GNT wins next contention. Reset mid-operation aborts it; no DONE issued.
- States: IDLE, PASS1, PASS2, DONE.
- IDLE: if any REQ high, grant: only one requester -> it; both -> the one not last served. Capture OP, D, AMT, owner id; pulse GNTx in that same cycle (combinational from REQ in IDLE, registered capture); update pointer; -> PASS1. Requester may drop REQ after GNT; operands need not stay stable.
- PASS1: SH_D=captured D. SRL: SH_AMT=AMT, SH_LNR=0. SLL: SH_AMT=AMT, SH_LNR=1. ROR: SH_AMT={27'b0,AMT[4:0]}, SH_LNR=0. ROL: same amount, SH_LNR=1. Latch SH_Y into accumulator. Next: SRL/SLL -> DONE; ROR/ROL with AMT[4:0]==0 -> DONE; otherwise -> PASS2.
- PASS2 (rotates only): SH_D=captured D, SH_AMT=32-AMT[4:0] (range 1..31), SH_LNR inverted vs PASS1. Accumulator <= accumulator | SH_Y; -> DONE.
- DONE: RESULT <= accumulator (visible that cycle via bypass, i.e. RESULT equals final accumulator while DONEx=1); DONEx=1 for the owner only; -> IDLE. No grant in DONE state; earliest new GNT is the following cycle.
- Latency GNT->DONE: 2 cycles for SRL/SLL and rotate-by-0 (mod 32); 3 cycles for rotate with AMT[4:0]!=0.
- Plain shifts pass full 32-bit AMT; AMT>=32 yields 0 from shifter. Rotates use AMT mod 32; upper AMT bits ignored.
- In IDLE and DONE, SH_* driven to 0.
- GNT0 and GNT1 never high together; DONE0/DONE1 never high together.

Test Plan:
- Reset then REQ0=1, OP0=SLL, D0=32'h0000_0001, AMT0=4 -> GNT0 same cycle, DONE0 2 cycles later, RESULT=32'h0000_0010; BUSY high between.
- REQ1, OP1=SRL, D1=32'h8000_0000, AMT1=32'h0000_0020 -> DONE1 after 2 cycles, RESULT=0.
- REQ0, OP0=ROR, D0=32'h0000_00F1, AMT0=4 -> DONE0 after 3 cycles, RESULT=32'h1000_000F; ROL D0=32'h8000_0001, AMT0=36 -> RESULT=32'h0000_0018.
- ROL with AMT0=32 and D0=32'hDEAD_BEEF -> no PASS2, DONE0 after 2 cycles, RESULT=32'hDEAD_BEEF.
- REQ0 and REQ1 held high continuously -> grants alternate 0,1,0,1 (FIRST_GNT=0), each DONE matches owner, no overlapping GNT/DONE.
- RST low during PASS2 of a rotate -> next cycle IDLE, BUSY=0, RESULT=0, no DONE; subsequent request served normally with FIRST_GNT priority.
